reg_timeout_src: RTL
====================

Name: reg_timeout_src

Overview:
- Source-domain register-bus guard placed directly upstream of the register-bus clock-domain crossing.
- Forwards requests unchanged. If a request waits too long for `ready`, it completes the transaction towards the master with an error response.
- Keeps the abandoned request asserted downstream until the crossing answers, then silently discards that late response. The crossing therefore never sees a protocol violation.
- Lets a dead or unclocked destination domain fail gracefully instead of hanging the source bus.

Parameters:
- req_t, logic, register-bus request struct (addr, write, wdata, wstrb, valid).
- rsp_t, logic, register-bus response struct (rdata, error, ready).
- TimeoutCycles, 1024, number of cycles `valid` may be held without `ready` before timeout fires; must be >= 2.
- ErrRdata, 32'hDEAD_BEEF, rdata returned on a timeout response.

Ports:
- src_clk_i  in  1  clock.
- src_rst_ni  in  1  reset; asynchronous, active-low.
- en_i  in  1  timeout enable; when 0 the block never times out.
- up_req_i  in  req_t  request from master.
- up_rsp_o  out  rsp_t  response to master.
- dn_req_o  out  req_t  request towards the crossing.
- dn_rsp_i  in  rsp_t  response from the crossing.
- timeout_o  out  1  single-cycle pulse when a timeout response is issued.
- timeout_cnt_o  out  16  saturating count of timeouts.
- clear_cnt_i  in  1  synchronous clear of timeout_cnt_o.

Behaviour:
- Reset is src_rst_ni (asynchronous, active-low), clock is src_clk_i. Reset values:
  - state Idle, cycle counter 0, req_q '0.
  - timeout_o 0, timeout_cnt_o 0.
- States: Idle, Pending, Drain.
- Idle:
  - dn_req_o = up_req_i and up_rsp_o = dn_rsp_i, combinational, zero latency.
  - up valid & dn ready: transaction completes in the same cycle; stay Idle.
  - up valid & !dn ready: counter <= 1, go to Pending.
- Pending:
  - Passthrough as in Idle. req_q captures up_req_i every cycle.
  - dn ready: response is forwarded, counter <= 0, go to Idle.
  - Else if counter == TimeoutCycles-1 and en_i:
    - up_rsp_o.ready = 1, error = 1, rdata = ErrRdata.
    - timeout_o = 1; dn_req_o still carries the request.
    - Go to Drain. The error ready occurs on the TimeoutCycles-th cycle of `valid`.
  - Else the counter increments, saturating at TimeoutCycles-1. With en_i = 0 it saturates, so a later en_i rise fires timeout on the first Pending cycle with en_i = 1.
  - up valid drops without ready (master protocol violation): go to Drain using req_q so the downstream handshake still completes. up_rsp_o.ready = 0.
- Drain:
  - dn_req_o = req_q with valid = 1.
  - up_rsp_o.ready = 0 and up_rsp_o.error = 0, so new master requests stall.
  - dn_req_o does not follow up_req_i.
  - On dn ready: response is discarded, counter <= 0, go to Idle. The next master request is forwarded from the following cycle.
  - No timeout in Drain; it waits indefinitely.
- Simultaneous dn ready and timeout condition: the real response wins; no error, no timeout_o.
- timeout_cnt_o:
  - +1 per timeout_o, saturating at 16'hFFFF.
  - clear_cnt_i alone gives 0.
  - clear_cnt_i together with timeout_o gives 1.
- Reset mid-Drain or mid-Pending: abandons the transaction. The crossing shares src_rst_ni, so both sides restart consistently.
- Width rule: counter width is $clog2(TimeoutCycles); the comparison is unsigned.

Decomposition:
- Shared package reg_timeout_pkg:
  - state_e enum {Idle, Pending, Drain}.
  - Default ErrRdata constant.
  - TimeoutCntWidth = 16.
- One sub-module: reg_timeout_counter. Saturating, loadable cycle counter with clear; instantiated once for cycles and once for timeout_cnt_o.
- FSM and muxing stay in the top module.

Test Plan (TimeoutCycles = 8, en_i = 1 unless stated):
- Read with dn ready 3 cycles after valid, rdata 0x1234 -> master sees ready on cycle 3, rdata 0x1234, error 0; timeout_o never asserts.
- Write to addr 0x40 with no dn ready for 20 cycles:
  - Cycle 8: up ready with error 1, rdata 0xDEADBEEF; timeout_o pulses once; timeout_cnt_o = 1.
  - dn_req_o stays valid with addr 0x40.
  - dn ready at cycle 20 is not forwarded upstream.
  - A following request to 0x44 reaches dn_req_o in cycle 21.
- dn ready exactly on cycle 8 -> real response forwarded, error 0, timeout_o 0, timeout_cnt_o unchanged.
- en_i = 0, stall for 50 cycles -> no response. Raise en_i at cycle 50 -> error response in that cycle, then Drain.
- Assert src_rst_ni low while in Drain:
  - All outputs return to reset values and state is Idle.
  - A preloaded timeout_cnt_o of 0xFFFF stays at 0xFFFF on a further timeout.
  - clear_cnt_i coinciding with a timeout gives 1.
- Master drops valid in Pending at cycle 4 -> dn_req_o still holds the captured request until dn ready, and master receives no response.

Source files
------------

// File: rtl/reg_timeout_pkg.sv
// Shared types and constants for the source-side register-bus timeout guard.
package reg_timeout_pkg;

  localparam int unsigned AddrWidth       = 32;
  localparam int unsigned DataWidth       = 32;
  localparam int unsigned StrbWidth       = DataWidth / 8;
  localparam int unsigned TimeoutCntWidth = 16;

  localparam logic [DataWidth-1:0] ErrRdataDefault = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Pending = 2'd1,
    Drain   = 2'd2
  } state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] wstrb;
    logic                 valid;
  } reg_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 ready;
  } reg_rsp_t;

endpackage

// File: rtl/reg_timeout_counter.sv
// Saturating up-counter with synchronous clear and load; clear then increment yields 1.
module reg_timeout_counter #(
  parameter int unsigned      Width  = 8,
  parameter logic [Width-1:0] MaxVal = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] r_cnt;
  logic [Width-1:0] w_base;
  logic [Width-1:0] w_next;

  always_comb begin
    w_base = clr_i ? '0 : r_cnt;
    w_next = w_base;
    if (load_i) begin
      w_next = load_val_i;
    end else if (inc_i && (w_base != MaxVal)) begin
      w_next = w_base + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_next;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/reg_timeout_src.sv
// Register-bus guard ahead of the clock-domain crossing: answers stalled requests with an
// error after TimeoutCycles, then keeps the request alive downstream until the crossing replies.
module reg_timeout_src
  import reg_timeout_pkg::*;
#(
  parameter type                  req_t         = reg_req_t,
  parameter type                  rsp_t         = reg_rsp_t,
  parameter int unsigned          TimeoutCycles = 1024,
  parameter logic [DataWidth-1:0] ErrRdata      = ErrRdataDefault
) (
  input  logic                       src_clk_i,
  input  logic                       src_rst_ni,
  input  logic                       en_i,
  input  req_t                       up_req_i,
  output rsp_t                       up_rsp_o,
  output req_t                       dn_req_o,
  input  rsp_t                       dn_rsp_i,
  output logic                       timeout_o,
  output logic [TimeoutCntWidth-1:0] timeout_cnt_o,
  input  logic                       clear_cnt_i
);

  localparam int unsigned         CntWidth = $clog2(TimeoutCycles);
  localparam logic [CntWidth-1:0] CntMax   = CntWidth'(TimeoutCycles - 1);

  localparam logic [1:0] StIdle    = 2'(Idle);
  localparam logic [1:0] StPending = 2'(Pending);
  localparam logic [1:0] StDrain   = 2'(Drain);

  logic [1:0]          r_state;
  logic [1:0]          w_state_d;
  req_t                r_req_q;
  req_t                w_req_held;
  req_t                w_dn_req;
  rsp_t                w_up_rsp;
  logic                w_timeout;
  logic                w_req_cap;
  logic                w_cyc_load;
  logic                w_cyc_clr;
  logic                w_cyc_inc;
  logic [CntWidth-1:0] w_cycles;

  // Next-state and output muxing
  always_comb begin
    w_state_d     = r_state;
    w_dn_req      = up_req_i;
    w_up_rsp      = dn_rsp_i;
    w_timeout     = 1'b0;
    w_req_cap     = 1'b0;
    w_cyc_load    = 1'b0;
    w_cyc_clr     = 1'b0;
    w_cyc_inc     = 1'b0;
    w_req_held    = r_req_q;
    w_req_held.valid = 1'b1;

    unique case (r_state)
      StIdle: begin
        if (up_req_i.valid) begin
          w_req_cap = 1'b1;
          if (!dn_rsp_i.ready) begin
            w_cyc_load = 1'b1;
            w_state_d  = StPending;
          end
        end
      end
      StPending: begin
        if (!up_req_i.valid) begin
          // Master abandoned the request; keep it alive downstream and hide the response.
          w_dn_req = w_req_held;
          w_up_rsp = '0;
          if (dn_rsp_i.ready) begin
            w_cyc_clr = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_state_d = StDrain;
          end
        end else begin
          w_req_cap = 1'b1;
          if (dn_rsp_i.ready) begin
            w_cyc_clr = 1'b1;
            w_state_d = StIdle;
          end else if (en_i && (w_cycles == CntMax)) begin
            w_up_rsp.rdata = ErrRdata;
            w_up_rsp.error = 1'b1;
            w_up_rsp.ready = 1'b1;
            w_timeout      = 1'b1;
            w_state_d      = StDrain;
          end else begin
            w_cyc_inc = 1'b1;
          end
        end
      end
      StDrain: begin
        w_dn_req = w_req_held;
        w_up_rsp = '0;
        if (dn_rsp_i.ready) begin
          w_cyc_clr = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      r_state <= StIdle;
      r_req_q <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_req_cap) begin
        r_req_q <= up_req_i;
      end
    end
  end

  reg_timeout_counter #(
    .Width  (CntWidth),
    .MaxVal (CntMax)
  ) u_cycle_cnt (
    .clk_i      (src_clk_i),
    .rst_ni     (src_rst_ni),
    .clr_i      (w_cyc_clr),
    .load_i     (w_cyc_load),
    .load_val_i (CntWidth'(1)),
    .inc_i      (w_cyc_inc),
    .cnt_o      (w_cycles)
  );

  reg_timeout_counter #(
    .Width (TimeoutCntWidth)
  ) u_timeout_cnt (
    .clk_i      (src_clk_i),
    .rst_ni     (src_rst_ni),
    .clr_i      (clear_cnt_i),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (w_timeout),
    .cnt_o      (timeout_cnt_o)
  );

  assign dn_req_o  = w_dn_req;
  assign up_rsp_o  = w_up_rsp;
  assign timeout_o = w_timeout;

endmodule
